// File: rtl/wb_arbiter_if.sv
// Bus bundle between functional units, the writeback arbiter and the register file.
// The master side produces results; the slave side (the arbiter) accepts and writes them.
interface wb_arbiter_if #(
    parameter int NUM_FUS = 4,
    parameter int DATA_W  = 32,
    parameter int PREG_W  = 6
);
    localparam int OCC_W = $clog2(NUM_FUS + 1);

    logic [NUM_FUS-1:0]             fu_valid;
    logic [NUM_FUS-1:0][PREG_W-1:0] fu_dst;
    logic [NUM_FUS-1:0][DATA_W-1:0] fu_val;
    logic [NUM_FUS-1:0]             fu_ready;

    logic [NUM_FUS-1:0]             fwd_valid;
    logic [NUM_FUS-1:0][PREG_W-1:0] fwd_dst;
    logic [NUM_FUS-1:0][DATA_W-1:0] fwd_val;

    logic                           wb_fwd_valid;
    logic [PREG_W-1:0]              wb_fwd_dst;
    logic [DATA_W-1:0]              wb_fwd_val;

    logic                           rf_we;
    logic [PREG_W-1:0]              rf_waddr;
    logic [DATA_W-1:0]              rf_wdata;

    logic [OCC_W-1:0]               occupancy;

    modport master (
        output fu_valid, fu_dst, fu_val,
        input  fu_ready, fwd_valid, fwd_dst, fwd_val,
        input  wb_fwd_valid, wb_fwd_dst, wb_fwd_val,
        input  rf_we, rf_waddr, rf_wdata, occupancy
    );

    modport slave (
        input  fu_valid, fu_dst, fu_val,
        output fu_ready, fwd_valid, fwd_dst, fwd_val,
        output wb_fwd_valid, wb_fwd_dst, wb_fwd_val,
        output rf_we, rf_waddr, rf_wdata, occupancy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per FU, round-robin grant to a single RF write port,
// with per-slot and write-stage forwarding broadcasts.
module wb_arbiter_slot #(
    parameter int DATA_W = 32,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              take_i,
    input  logic              clear_i,
    input  logic [PREG_W-1:0] dst_i,
    input  logic [DATA_W-1:0] val_i,
    output logic              valid_o,
    output logic [PREG_W-1:0] dst_o,
    output logic [DATA_W-1:0] val_o
);
    logic              valid_q, valid_d;
    logic [PREG_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] val_q, val_d;

    // A refill on the granting edge wins over the clear.
    always_comb begin
        valid_d = valid_q;
        dst_d   = dst_q;
        val_d   = val_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (take_i) begin
            valid_d = 1'b1;
            dst_d   = dst_i;
            val_d   = val_i;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dst_q   <= '0;
            val_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dst_q   <= dst_d;
            val_q   <= val_d;
        end
    end

    assign valid_o = valid_q;
    assign dst_o   = dst_q;
    assign val_o   = val_q;
endmodule

module wb_arbiter #(
    parameter int NUM_FUS = 4,
    parameter int DATA_W  = 32,
    parameter int PREG_W  = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;
    localparam int OCC_W = $clog2(NUM_FUS + 1);

    logic [NUM_FUS-1:0]             slot_v, take, gnt, ready;
    logic [NUM_FUS-1:0][PREG_W-1:0] slot_dst;
    logic [NUM_FUS-1:0][DATA_W-1:0] slot_val;

    logic [PTR_W-1:0]  rr_q, rr_d, gnt_idx;
    logic              gnt_vld;
    logic              rf_we_q, rf_we_d;
    logic [PREG_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    int                nfill;

    // First valid slot at or after rr_q, wrapping; flush suppresses the grant.
    always_comb begin : arb
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        idx     = 0;
        if (!flush) begin
            for (int k = 0; k < NUM_FUS; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NUM_FUS) idx = idx - NUM_FUS;
                if (!gnt_vld && slot_v[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(idx);
                end
            end
        end
        if (gnt_vld) gnt[gnt_idx] = 1'b1;
    end

    assign ready = (rst || flush) ? '0 : (~slot_v | gnt);

    for (genvar i = 0; i < NUM_FUS; i++) begin : g_slot
        // Writes to physical register 0 are handshaken and dropped.
        assign take[i] = bus.fu_valid[i] & ready[i] & (|bus.fu_dst[i]);

        wb_arbiter_slot #(.DATA_W(DATA_W), .PREG_W(PREG_W)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .take_i  (take[i]),
            .clear_i (gnt[i]),
            .dst_i   (bus.fu_dst[i]),
            .val_i   (bus.fu_val[i]),
            .valid_o (slot_v[i]),
            .dst_o   (slot_dst[i]),
            .val_o   (slot_val[i])
        );
    end

    always_comb begin
        nfill = 0;
        for (int i = 0; i < NUM_FUS; i++) nfill = nfill + int'(take[i]);
    end

    always_comb begin
        rr_d    = rr_q;
        rf_we_d = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        occ_d   = OCC_W'(int'(occ_q) + nfill - int'(gnt_vld));
        if (flush) occ_d = '0;
        if (gnt_vld) begin
            rf_we_d = 1'b1;
            waddr_d = slot_dst[gnt_idx];
            wdata_d = slot_val[gnt_idx];
            rr_d    = (gnt_idx == PTR_W'(NUM_FUS - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            rf_we_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            occ_q   <= '0;
        end else begin
            rr_q    <= rr_d;
            rf_we_q <= rf_we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            occ_q   <= occ_d;
        end
    end

    assign bus.fu_ready     = ready;
    assign bus.fwd_valid    = slot_v;
    assign bus.fwd_dst      = slot_dst;
    assign bus.fwd_val      = slot_val;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = waddr_q;
    assign bus.rf_wdata     = wdata_q;
    assign bus.wb_fwd_valid = rf_we_q;
    assign bus.wb_fwd_dst   = waddr_q;
    assign bus.wb_fwd_val   = wdata_q;
    assign bus.occupancy    = occ_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic, all checked every cycle
// against a slot/queue-level reference model.
module tb_wb_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int PW = 6;

    logic clk = 1'b0;
    logic rst, flush;
    always #5 clk = ~clk;

    wb_arbiter_if #(.NUM_FUS(N), .DATA_W(DW), .PREG_W(PW)) bus();

    wb_arbiter #(.NUM_FUS(N), .DATA_W(DW), .PREG_W(PW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    int nchk = 0;
    int npass = 0;

    // Reference model: which slots hold what, the RR pointer, and the pending write.
    bit            m_v[N];
    logic [PW-1:0] m_dst[N];
    logic [DW-1:0] m_val[N];
    int            m_rr;
    bit            m_we;
    logic [PW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic int m_gnt();
        if (flush) return -1;
        for (int k = 0; k < N; k++)
            if (m_v[(m_rr + k) % N]) return (m_rr + k) % N;
        return -1;
    endfunction

    function automatic bit m_ready(input int i, input int g);
        return !rst && !flush && (!m_v[i] || g == i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_rr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_edge();
        int g;
        bit rdy[N];
        g = m_gnt();
        for (int i = 0; i < N; i++) rdy[i] = m_ready(i, g);
        if (rst) model_reset();
        else if (flush) begin
            for (int i = 0; i < N; i++) m_v[i] = 1'b0;
            m_we = 1'b0;
        end else begin
            m_we = (g >= 0);
            if (g >= 0) begin
                m_waddr = m_dst[g]; m_wdata = m_val[g];
                m_v[g] = 1'b0; m_rr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++)
                if (bus.fu_valid[i] && rdy[i] && bus.fu_dst[i] != 0) begin
                    m_v[i] = 1'b1; m_dst[i] = bus.fu_dst[i]; m_val[i] = bus.fu_val[i];
                end
        end
    endtask

    task automatic check_all();
        int g, occ;
        g = m_gnt(); occ = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fu_ready[%0d]", i), bus.fu_ready[i], m_ready(i, g));
            chk($sformatf("fwd_valid[%0d]", i), bus.fwd_valid[i], m_v[i]);
            if (m_v[i]) begin
                occ++;
                chk($sformatf("fwd_dst[%0d]", i), bus.fwd_dst[i], m_dst[i]);
                chk($sformatf("fwd_val[%0d]", i), bus.fwd_val[i], m_val[i]);
            end
        end
        chk("occupancy", bus.occupancy, occ);
        chk("rf_we", bus.rf_we, m_we);
        chk("wb_fwd_valid", bus.wb_fwd_valid, m_we);
        if (m_we) begin
            chk("rf_waddr", bus.rf_waddr, m_waddr);
            chk("rf_wdata", bus.rf_wdata, m_wdata);
            chk("wb_fwd_dst", bus.wb_fwd_dst, m_waddr);
            chk("wb_fwd_val", bus.wb_fwd_val, m_wdata);
        end
    endtask

    // Inputs are set just after a falling edge; outputs checked 1 time unit later.
    task automatic cyc();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic offer(input int i, input int d, input int v);
        bus.fu_valid[i] = 1'b1;
        bus.fu_dst[i]   = PW'(d);
        bus.fu_val[i]   = DW'(v);
    endtask

    task automatic idle();
        bus.fu_valid = '0;
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        bus.fu_valid = '0; bus.fu_dst = '0; bus.fu_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        #1;
        chk("reset rf_we", bus.rf_we, 0);
        chk("reset rf_waddr", bus.rf_waddr, 0);
        chk("reset rf_wdata", bus.rf_wdata, 0);
        chk("reset occupancy", bus.occupancy, 0);
        chk("reset fwd_valid", bus.fwd_valid, 0);

        // Single result
        offer(0, 21, 21); cyc(); idle();
        chk("single fwd_valid0", bus.fwd_valid[0], 1);
        chk("single fwd_dst0", bus.fwd_dst[0], 21);
        chk("single occ1", bus.occupancy, 1);
        cyc();
        chk("single rf_we", bus.rf_we, 1);
        chk("single waddr", bus.rf_waddr, 21);
        chk("single wdata", bus.rf_wdata, 21);
        chk("single occ0", bus.occupancy, 0);
        cyc();
        chk("single we drop", bus.rf_we, 0);

        // Round-robin order
        do_reset();
        for (int i = 0; i < N; i++) offer(i, 5 + i, 100 + i);
        cyc(); idle();
        for (int i = 0; i < N; i++) begin
            cyc();
            chk("rr we", bus.rf_we, 1);
            chk("rr waddr", bus.rf_waddr, 5 + i);
        end

        // Backpressure with all slots full
        do_reset();
        for (int i = 0; i < N; i++) offer(i, 10 + i, 200 + i);
        cyc(); idle();
        offer(1, 9, 'h99);
        #1 chk("bp ready1 stalled", bus.fu_ready[1], 0);
        cyc();
        chk("bp waddr 10", bus.rf_waddr, 10);
        chk("bp ready1 granted", bus.fu_ready[1], 1);
        cyc(); idle();
        chk("bp waddr 11", bus.rf_waddr, 11);
        cyc(); chk("bp waddr 12", bus.rf_waddr, 12);
        cyc(); chk("bp waddr 13", bus.rf_waddr, 13);
        cyc(); chk("bp waddr 9", bus.rf_waddr, 9);
        chk("bp wdata 99", bus.rf_wdata, 'h99);

        // Zero destination register
        do_reset();
        offer(2, 0, 99);
        #1 chk("zero ready2", bus.fu_ready[2], 1);
        cyc(); idle();
        chk("zero occ", bus.occupancy, 0);
        chk("zero fwd_valid2", bus.fwd_valid[2], 0);
        cyc();
        chk("zero rf_we", bus.rf_we, 0);

        // Flush
        do_reset();
        for (int i = 0; i < 3; i++) offer(i, 30 + i, 300 + i);
        cyc(); idle();
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("flush occ", bus.occupancy, 0);
        chk("flush fwd_valid", bus.fwd_valid, 0);
        chk("flush rf_we", bus.rf_we, 0);
        cyc();
        chk("flush rf_we later", bus.rf_we, 0);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) offer(i, 40 + i, 400 + i);
        cyc(); idle();
        cyc();
        chk("rst pre we", bus.rf_we, 1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("rst we", bus.rf_we, 0);
        chk("rst waddr", bus.rf_waddr, 0);
        chk("rst wdata", bus.rf_wdata, 0);
        chk("rst occ", bus.occupancy, 0);
        chk("rst fwd_valid", bus.fwd_valid, 0);
        offer(3, 50, 1); offer(0, 51, 2);
        cyc(); idle();
        cyc();
        chk("rst resume FU0 first", bus.rf_waddr, 51);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            bus.fu_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.fu_dst[i] = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom_range(1, (1 << PW) - 1));
                bus.fu_val[i] = DW'($urandom);
            end
            flush = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; idle();
        repeat (6) cyc();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_FUS, default 4: number of functional-unit result sources.
REQ-002 Parameter DATA_W, default 32: result value width.
REQ-003 Parameter PREG_W, default 6: physical register index width.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port flush, input, 1: synchronous squash of all buffered results.
REQ-007 Port fu_valid, input, NUM_FUS: per-FU result offered.
REQ-008 Port fu_dst, input, NUM_FUS x PREG_W: per-FU destination physical register.
REQ-009 Port fu_val, input, NUM_FUS x DATA_W: per-FU result value.
REQ-010 Port fu_ready, output, NUM_FUS: per-FU result accepted this cycle.
REQ-011 Port fwd_valid / fwd_dst / fwd_val, output, NUM_FUS x (1 / PREG_W / DATA_W): per-FU forwarding broadcast of the buffered result.
REQ-012 Port wb_fwd_valid / wb_fwd_dst / wb_fwd_val, output, 1 / PREG_W / DATA_W: forwarding broadcast of the result being written this cycle.
REQ-013 Port rf_we / rf_waddr / rf_wdata, output, 1 / PREG_W / DATA_W: register-file write port.
REQ-014 Port occupancy, output, $clog2(NUM_FUS+1): count of buffered entries.

Function
REQ-015 Each FU owns one holding slot (valid, dst, val); a transfer occurs when fu_valid[i] and fu_ready[i] are both high at a rising edge.
REQ-016 fu_ready[i] SHALL be high when slot i is empty or slot i is granted this cycle, and low during flush; combinational from slot state, grant and flush only, never from fu_valid.
REQ-017 A transfer with fu_dst == 0 SHALL complete the handshake but is discarded: no slot fill, no write, no forward.
REQ-018 Arbiter: round-robin among valid slots, one grant per cycle; search starts at pointer rr_ptr and wraps modulo NUM_FUS.
REQ-019 On a grant to slot g, rr_ptr SHALL advance to (g+1) mod NUM_FUS; no grant leaves rr_ptr unchanged.
REQ-020 On the granting edge, the granted slot is cleared (or refilled by a simultaneous transfer) and rf_we/rf_waddr/rf_wdata are registered from it; rf_we is high for exactly the following cycle.
REQ-021 Latency: result accepted at edge N, earliest grant in cycle N..N+1, earliest rf_we cycle N+1 (after edge N+1); minimum accept-to-write = 1 cycle after capture.
REQ-022 fwd_valid[i]/fwd_dst[i]/fwd_val[i] SHALL mirror slot i contents directly; wb_fwd_* SHALL mirror rf_we/rf_waddr/rf_wdata, so a result is forwardable continuously from capture until its write cycle ends.
REQ-023 occupancy SHALL equal the number of valid slots; range 0..NUM_FUS; next value = current + fills − grant, no overflow possible.
REQ-024 Flush: at the edge with flush high, all slots clear, rf_we clears next cycle, no transfer is accepted, rr_ptr unchanged; flush overrides simultaneous grant and transfer.
REQ-025 All slots full: fu_ready high only for the granted FU; others stall with inputs held by the producer.
REQ-026 Two slots holding the same fu_dst are written in arbitration order; no merging.

Reset
REQ-027 On rst at a rising edge: all slots invalid, rr_ptr = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, occupancy = 0; hence fwd_valid = 0, wb_fwd_valid = 0.
REQ-028 During rst, fu_ready SHALL be 0; rst mid-operation discards all buffered results without writing them; rst overrides flush.

Verification
REQ-029 Single result: FU0 offers dst=21,val=21 one cycle -> fwd_valid[0]=1 dst 21 next cycle; rf_we=1 waddr=21 wdata=21 one cycle later; occupancy 1 then 0.
REQ-030 Round-robin: FU0..FU3 offer dst 5,6,7,8 same cycle -> writes in order 5,6,7,8 on four consecutive rf_we cycles; rr_ptr returns to 0.
REQ-031 Backpressure: all four slots full, FU1 offers new dst=9 -> fu_ready[1]=0 until slot 1 granted, then accepted same cycle; dst 9 written after other pending entries per pointer.
REQ-032 Zero register: FU2 offers dst=0,val=99 -> fu_ready[2]=1, occupancy stays 0, no rf_we, fwd_valid[2]=0.
REQ-033 Flush: three slots full, flush pulsed one cycle -> occupancy 0, fwd_valid all 0, rf_we 0 next cycle, no write of the squashed values.
REQ-034 Reset mid-stream: rst asserted with two slots full and rf_we high -> next cycle all outputs at reset values, following fill resumes grant search from FU0.
